// File: rtl/wb_spi_sram_pkg.sv
// Shared types for the Wishbone-to-serial-SRAM bridge: FSM state encoding,
// SPI opcodes, Wishbone CTI/BTE codes and a burst-type helper.
package wb_spi_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ACK,
        ST_WAIT,
        ST_DESEL
    } state_t;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    function automatic logic is_lin_incr(logic [2:0] cti, logic [1:0] bte);
        return (cti == CTI_INCR) && (bte == BTE_LINEAR);
    endfunction

endpackage

// File: rtl/wb_spi_sram_shifter.sv
// SPI mode-0 shift engine: loads up to 32 MSB-aligned bits and a bit count,
// drives sck/mosi at clk/2 and samples miso at the end of each high phase.
// Ports: i_load/i_data/i_bits start a stream, i_abort kills it,
// o_done flags the last bit's closing edge, o_rx is the received byte
// including the miso bit sampled on that edge.
module spi_shifter
    import wb_spi_sram_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_load,
    input  logic        i_abort,
    input  logic [31:0] i_data,
    input  logic [5:0]  i_bits,
    input  logic        i_miso,
    output logic        o_sck,
    output logic        o_mosi,
    output logic        o_done,
    output logic [7:0]  o_rx
);

    logic [31:0] r_shift;
    logic [5:0]  r_cnt;
    logic        r_ph;
    logic [7:0]  r_rx;
    logic        w_busy;

    assign w_busy = (r_cnt != 6'd0);
    assign o_sck  = w_busy & r_ph;
    assign o_mosi = w_busy & r_shift[31];
    assign o_done = w_busy & r_ph & (r_cnt == 6'd1);
    assign o_rx   = {r_rx[6:0], i_miso};

    // A load on the closing edge of the last bit takes priority, so the
    // next stream starts with no idle bit period in between.
    always_ff @(posedge clk_i) begin
        if (rst_i || i_abort) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_ph    <= 1'b0;
            r_rx    <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= i_bits;
            r_ph    <= 1'b0;
        end else if (w_busy) begin
            if (r_ph) begin
                r_shift <= {r_shift[30:0], 1'b0};
                r_rx    <= o_rx;
                r_cnt   <= r_cnt - 6'd1;
            end
            r_ph <= ~r_ph;
        end
    end

endmodule

// File: rtl/wb_spi_sram.sv
// Wishbone B4 slave bridging 8-bit single/burst accesses onto a 23LC1024-class
// SPI SRAM (mode 0, sequential). Ports: wbs_* Wishbone slave, spi_* SRAM bus.
// Macro WB_SPI_SRAM_BURST_EN keeps linear incrementing bursts in one cs_n window.
module wb_spi_sram
    import wb_spi_sram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 24,
    parameter int DATA_WIDTH      = 8,
    parameter int SEL_WIDTH       = DATA_WIDTH / 8,
    parameter int DESELECT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [SEL_WIDTH-1:0]  wbs_sel_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    input  logic [2:0]            wbs_cti_i,
    input  logic [1:0]            wbs_bte_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_rty_o,
    output logic                  wbs_err_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_n_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_dat_o;
    logic [7:0]            r_dcnt;
    logic                  w_req;
    logic                  w_load;
    logic                  w_abort;
    logic [31:0]           w_ld_data;
    logic [5:0]            w_ld_bits;
    logic                  w_done;
    logic [7:0]            w_rx;
    logic                  w_unused;

`ifdef WB_SPI_SRAM_BURST_EN
    logic                  r_burst;
    logic [ADDR_WIDTH-1:0] w_adr_inc;
    logic                  w_cont;

    // Address increment wraps naturally at 2^ADDR_WIDTH.
    assign w_adr_inc = r_adr + 1'b1;
    assign w_cont    = (wbs_adr_i == w_adr_inc) && (wbs_we_i == r_we);
    assign w_unused  = ^wbs_sel_i;
`else
    assign w_unused  = ^{wbs_sel_i, wbs_cti_i, wbs_bte_i};
`endif

    assign w_req      = wbs_cyc_i & wbs_stb_i;
    assign wbs_ack_o  = (r_state == ST_ACK);
    assign wbs_rty_o  = 1'b0;
    assign wbs_err_o  = 1'b0;
    assign wbs_dat_o  = r_dat_o;
    assign spi_cs_n_o = (r_state == ST_IDLE) || (r_state == ST_DESEL);

    spi_shifter u_shifter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_load),
        .i_abort (w_abort),
        .i_data  (w_ld_data),
        .i_bits  (w_ld_bits),
        .i_miso  (spi_miso_i),
        .o_sck   (spi_sck_o),
        .o_mosi  (spi_mosi_o),
        .o_done  (w_done),
        .o_rx    (w_rx)
    );

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_abort   = 1'b0;
        w_ld_data = '0;
        w_ld_bits = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next    = ST_CMD;
                    w_load    = 1'b1;
                    w_ld_data = {wbs_we_i ? SPI_OP_WRITE : SPI_OP_READ, 24'h0};
                    w_ld_bits = 6'd8;
                end
            end
            ST_CMD: begin
                if (!wbs_cyc_i) begin
                    w_next  = ST_DESEL;
                    w_abort = 1'b1;
                end else if (w_done) begin
                    w_next    = ST_ADDR;
                    w_load    = 1'b1;
                    w_ld_data = 32'(r_adr) << (32 - ADDR_WIDTH);
                    w_ld_bits = 6'(ADDR_WIDTH);
                end
            end
            ST_ADDR: begin
                if (!wbs_cyc_i) begin
                    w_next  = ST_DESEL;
                    w_abort = 1'b1;
                end else if (w_done) begin
                    // Reads shift out zeros while the SRAM drives miso.
                    w_next    = ST_DATA;
                    w_load    = 1'b1;
                    w_ld_data = {r_dat & {DATA_WIDTH{r_we}}, 24'h0};
                    w_ld_bits = 6'd8;
                end
            end
            ST_DATA: begin
                if (!wbs_cyc_i) begin
                    w_next  = ST_DESEL;
                    w_abort = 1'b1;
                end else if (w_done) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK: begin
                w_next = ST_DESEL;
`ifdef WB_SPI_SRAM_BURST_EN
                if (r_burst) begin
                    w_next = ST_WAIT;
                end
`endif
            end
            ST_WAIT: begin
`ifdef WB_SPI_SRAM_BURST_EN
                // cs_n stays low; a sequential beat jumps straight to DATA.
                if (!wbs_cyc_i) begin
                    w_next = ST_DESEL;
                end else if (wbs_stb_i) begin
                    if (w_cont) begin
                        w_next    = ST_DATA;
                        w_load    = 1'b1;
                        w_ld_data = {wbs_dat_i & {DATA_WIDTH{wbs_we_i}}, 24'h0};
                        w_ld_bits = 6'd8;
                    end else begin
                        w_next = ST_DESEL;
                    end
                end
`else
                w_next = ST_DESEL;
`endif
            end
            ST_DESEL: begin
                if (r_dcnt == 8'(DESELECT_CYCLES - 1)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
            r_dat_o <= '0;
            r_dcnt  <= '0;
`ifdef WB_SPI_SRAM_BURST_EN
            r_burst <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_dcnt  <= (r_state == ST_DESEL) ? r_dcnt + 8'd1 : 8'd0;
            if (r_state == ST_IDLE && w_req) begin
                r_adr <= wbs_adr_i;
                r_we  <= wbs_we_i;
                r_dat <= wbs_dat_i;
`ifdef WB_SPI_SRAM_BURST_EN
                r_burst <= is_lin_incr(wbs_cti_i, wbs_bte_i);
`endif
            end
`ifdef WB_SPI_SRAM_BURST_EN
            if (r_state == ST_WAIT && w_next == ST_DATA) begin
                r_adr   <= wbs_adr_i;
                r_dat   <= wbs_dat_i;
                r_burst <= is_lin_incr(wbs_cti_i, wbs_bte_i);
            end
`endif
            if (r_state == ST_DATA && w_next == ST_ACK && !r_we) begin
                r_dat_o <= w_rx;
            end
        end
    end

endmodule
